// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// The optional fetch-fairness counter is enabled by MEM_ARB_FAIRNESS_EN.
package mem_arb_pkg;

  localparam int WORD_WIDTH_DEF   = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERV_D = 3'd1,
    SERV_I = 3'd2,
    DONE_D = 3'd3,
    DONE_I = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision for the memory arbiter: data port wins by default.
// With MEM_ARB_FAIRNESS_EN a starvation counter forces a fetch grant.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
`ifdef MEM_ARB_FAIRNESS_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic idle,
  input  logic if_req,
  input  logic d_req,
  output logic gnt_d,
  output logic gnt_i
);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  // Only meaningful while a fetch is actually waiting.
  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT)) && if_req;

  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if (idle) begin
      if (d_req && !starved) gnt_d = 1'b1;
      else if (if_req)       gnt_i = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (gnt_i) begin
      starve_cnt <= '0;
    end else if (gnt_d && if_req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign gnt_d = idle & d_req;
  assign gnt_i = idle & ~d_req & if_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory.
// Build option MEM_ARB_FAIRNESS_EN adds fetch anti-starvation in mem_arb_grant.
//
// state  | meaning
// IDLE   | no transaction, arbitrate requests
// SERV_D | data access on the memory bus, waiting for mem_ack
// SERV_I | fetch on the memory bus, waiting for mem_ack
// DONE_D | d_ready pulse, back to IDLE
// DONE_I | if_ready pulse, back to IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_WIDTH   = WORD_WIDTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [WORD_WIDTH-1:0] if_addr,
  output logic [WORD_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [WORD_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  stall_if,
  output logic                  stall_mem
);

  arb_state_t            state;
  logic                  gnt_d;
  logic                  gnt_i;
  logic [WORD_WIDTH-1:0] lat_addr;
  logic [WORD_WIDTH-1:0] lat_wdata;
  logic                  lat_we;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
`ifdef MEM_ARB_FAIRNESS_EN
    .clk   (clk),
    .reset (reset),
`endif
    .idle  (state == IDLE),
    .if_req(if_req),
    .d_req (d_req),
    .gnt_d (gnt_d),
    .gnt_i (gnt_i)
  );

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_d) begin
            state     <= SERV_D;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_we    <= d_we;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
          end else if (gnt_i) begin
            state     <= SERV_I;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
          end
        end
        SERV_D: begin
          if (mem_ack) begin
            state   <= DONE_D;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_ready <= 1'b1;
            if (!lat_we) d_rdata <= mem_rdata;
          end
        end
        SERV_I: begin
          if (mem_ack) begin
            state    <= DONE_I;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        DONE_D: begin
          state   <= IDLE;
          d_ready <= 1'b0;
        end
        DONE_I: begin
          state    <= IDLE;
          if_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int W     = 32;
  localparam int LIMIT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         if_req = 1'b0;
  logic [W-1:0] if_addr = '0;
  logic [W-1:0] if_rdata;
  logic         if_ready;
  logic         d_req = 1'b0;
  logic         d_we = 1'b0;
  logic [W-1:0] d_addr = '0;
  logic [W-1:0] d_wdata = '0;
  logic [W-1:0] d_rdata;
  logic         d_ready;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         stall_if;
  logic         stall_mem;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mem_arbiter #(.WORD_WIDTH(W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Transaction model: who owns the bus (0 none, 1 data, 2 fetch) and who
  // is showing a ready pulse this cycle.
  int           m_srv = 0;
  int           m_done = 0;
  logic [W-1:0] m_addr = '0;
  logic [W-1:0] m_wdata = '0;
  logic         m_we = 1'b0;
  logic [W-1:0] m_drdata = '0;
  logic [W-1:0] m_irdata = '0;
  int           m_starve = 0;

  always @(posedge clk or negedge reset) begin
    int who;
    if (!reset) begin
      m_srv = 0; m_done = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
      m_drdata = '0; m_irdata = '0; m_starve = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_srv != 0) begin
      if (mem_ack) begin
        if (m_srv == 2) m_irdata = mem_rdata;
        else if (!m_we) m_drdata = mem_rdata;
        m_done = m_srv;
        m_srv  = 0;
      end
    end else begin
      who = d_req ? 1 : (if_req ? 2 : 0);
`ifdef MEM_ARB_FAIRNESS_EN
      if (d_req && if_req && m_starve == LIMIT) who = 2;
`endif
      if (who == 1) begin
        m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
        if (if_req && m_starve < LIMIT) m_starve++;
      end else if (who == 2) begin
        m_addr = if_addr; m_we = 1'b0;
        m_starve = 0;
      end
      m_srv = who;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", mem_req, m_srv != 0);
      chk("mem_we", mem_we, m_srv == 1 && m_we);
      if (m_srv != 0) chk("mem_addr", mem_addr, m_addr);
      if (m_srv == 1 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("d_ready", d_ready, m_done == 1);
      chk("if_ready", if_ready, m_done == 2);
      chk("d_rdata", d_rdata, m_drdata);
      chk("if_rdata", if_rdata, m_irdata);
      chk("stall_mem", stall_mem, d_req && m_done != 1);
      chk("stall_if", stall_if, if_req && m_done != 2);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((d_req || if_req || m_srv != 0 || m_done != 0) && n < 60) begin
      if (m_done == 1) d_req = 1'b0;
      if (m_done == 2) if_req = 1'b0;
      mem_ack = (m_srv != 0);
      step();
      n++;
    end
    mem_ack = 1'b0;
    chk("drain_timeout", (n < 60), 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, we_cnt, rdy_cnt;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    reset = 1'b1;
    step();

    // Fetch with one-cycle ack
    if_req = 1'b1; if_addr = 32'h40;
    step();
    chk("t18_req", mem_req, 1'b1);
    chk("t18_addr", mem_addr, 32'h40);
    mem_ack = 1'b1; mem_rdata = 32'h2402000A;
    step();
    chk("t18_ready", if_ready, 1'b1);
    chk("t18_rdata", if_rdata, 32'h2402000A);
    if_req = 1'b0; mem_ack = 1'b0;
    step();
    chk("t18_ready_once", if_ready, 1'b0);
    chk("t18_stall", stall_if, 1'b0);

    // Simultaneous requests: data first, fetch three cycles after d_ready
    d_addr = 32'h100; d_we = 1'b0; if_addr = 32'h200;
    d_req = 1'b1; if_req = 1'b1;
    step();
    chk("t19_d_first", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    step();
    chk("t19_d_ready", d_ready, 1'b1);
    chk("t19_d_rdata", d_rdata, 32'h11112222);
    d_req = 1'b0; mem_rdata = 32'h33334444;
    n = 0;
    do begin step(); n++; end while (!if_ready && n < 10);
    chk("t19_gap", n, 3);
    chk("t19_i_rdata", if_rdata, 32'h33334444);
    if_req = 1'b0; mem_ack = 1'b0;
    step();

    // Store with ack in the third bus cycle
    d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    mem_rdata = 32'h55556666;
    k = 0; we_cnt = 0; rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      we_cnt += int'(mem_we);
      rdy_cnt += int'(d_ready);
      if (d_ready) d_req = 1'b0;
      if (mem_req) begin
        k++;
        if (k == 1) chk("t20_wdata", mem_wdata, 32'hDEADBEEF);
      end
      mem_ack = mem_req && (k == 3);
    end
    chk("t20_we_cycles", we_cnt, 3);
    chk("t20_ready_count", rdy_cnt, 1);
    chk("t20_rdata_kept", d_rdata, 32'h11112222);

    // Reset during a data access, late ack ignored
    d_we = 1'b0; d_addr = 32'h24; d_req = 1'b1;
    step();
    chk("t22_req_before", mem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("t22_req_drop", mem_req, 1'b0);
    chk("t22_no_ready", d_ready, 1'b0);
    d_req = 1'b0;
    step();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77778888;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t22_idle_req", mem_req, 1'b0);
      chk("t22_idle_ready", d_ready, 1'b0);
      step();
    end
    chk("t22_rdata_clr", d_rdata, 32'h0);

`ifdef MEM_ARB_FAIRNESS_EN
    begin
      string exp_order = "DDDDID";
      string got_order = "";
      logic  prev_req = 1'b0;
      d_addr = 32'h100; if_addr = 32'h200; d_we = 1'b0;
      d_req = 1'b1; if_req = 1'b1;
      n = 0;
      while (got_order.len() < 6 && n < 80) begin
        step();
        n++;
        if (mem_req && !prev_req) got_order = {got_order, (mem_addr == 32'h200) ? "I" : "D"};
        prev_req = mem_req;
        mem_ack = mem_req;
      end
      for (int i = 0; i < 6; i++)
        chk($sformatf("t21_grant%0d", i),
            (i < got_order.len()) ? W'(got_order[i]) : W'(0), W'(exp_order[i]));
      drain();
    end
`endif

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      if (d_req && m_done == 1) d_req = 1'($urandom_range(0, 1));
      else if (!d_req) d_req = ($urandom_range(0, 2) == 0);
      if (if_req && m_done == 2) if_req = 1'($urandom_range(0, 1));
      else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      d_we = 1'($urandom_range(0, 1));
      d_addr = $urandom; d_wdata = $urandom; if_addr = $urandom;
      mem_rdata = $urandom;
      mem_ack = (m_srv != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
    end
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
